intra_blk_scanner: RTL and testbench

Upstream address sequencer for `intraloop`. It walks one luma frame in 4x4-block steps and presents each block position as `mbnumber = {row, col}` over a valid/ready handshake, one block per transfer. It replaces free-running stimulus generation with a synthesizable, back-pressurable source, and signals end of frame.

---
 rtl/intra_pkg.sv | 19 +
 rtl/intra_blk_idx2xy.sv | 13 +
 rtl/intra_blk_scanner.sv | 150 +++++++++++++++
 tb/tb_intra_blk_scanner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared types and constants for the intra block scanner.
// The scanner's optional MB visit order is selected by INTRA_SCAN_MB_ORDER_EN.
package intra_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
    } blk_coord_t;

    localparam int BLK_SIZE = 4;
    localparam int MB_SIZE  = 16;

endpackage

// File: rtl/intra_blk_idx2xy.sv
// Maps an H.264 luma 4x4 block index (0..15) to its pixel offset inside a 16x16 MB.
// Used only when INTRA_SCAN_MB_ORDER_EN is defined.
module intra_blk_idx2xy (
    input  logic [3:0] blk,
    output logic [3:0] off_x,
    output logic [3:0] off_y
);

    // x = blk[2]*8 + blk[0]*4, y = blk[3]*8 + blk[1]*4
    assign off_x = {blk[2], blk[0], 2'b00};
    assign off_y = {blk[3], blk[1], 2'b00};

endmodule

// File: rtl/intra_blk_scanner.sv
// Frame walker presenting 4x4 block positions {row, col} over valid/ready.
// INTRA_SCAN_MB_ORDER_EN selects 16x16 MB raster with H.264 block order inside each MB.
//
// state   | meaning
// IDLE    | waiting for start, outputs quiet
// RUN     | presenting positions, valid=1 busy=1
// DONE    | one-cycle frame_done pulse, then IDLE
module intra_blk_scanner
    import intra_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int LENGTH = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] mbnumber,
    output logic        last,
    output logic        busy,
    output logic        frame_done
);

    state_t     state, state_nxt;
    blk_coord_t pos, pos_nxt;
    logic       valid_nxt, busy_nxt, done_nxt, last_nxt;
    logic       last_at_nxt;
    logic       load, xfer;

    assign load     = (state == ST_IDLE) && start;
    assign xfer     = valid && ready;
    assign mbnumber = pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (xfer && last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        valid_nxt = (state_nxt == ST_RUN);
        busy_nxt  = (state_nxt == ST_RUN);
        done_nxt  = (state_nxt == ST_DONE);
        last_nxt  = (state_nxt == ST_RUN) && last_at_nxt;
    end

`ifdef INTRA_SCAN_MB_ORDER_EN
    localparam logic [15:0] MB_COL_LAST = 16'(WIDTH - MB_SIZE);
    localparam logic [15:0] MB_ROW_LAST = 16'(LENGTH - MB_SIZE);

    logic [15:0] mb_x, mb_y, mb_x_nxt, mb_y_nxt;
    logic [3:0]  blk, blk_nxt;
    logic [3:0]  off_x, off_y;

    intra_blk_idx2xy u_idx2xy (
        .blk   (blk_nxt),
        .off_x (off_x),
        .off_y (off_y)
    );

    always_comb begin
        mb_x_nxt = mb_x;
        mb_y_nxt = mb_y;
        blk_nxt  = blk;
        // Clearing on the final transfer leaves the counters at the frame origin in DONE/IDLE.
        if (load || (xfer && last)) begin
            mb_x_nxt = '0;
            mb_y_nxt = '0;
            blk_nxt  = '0;
        end else if (xfer) begin
            if (blk == 4'd15) begin
                blk_nxt = '0;
                if (mb_x == MB_COL_LAST) begin
                    mb_x_nxt = '0;
                    mb_y_nxt = mb_y + 16'(MB_SIZE);
                end else begin
                    mb_x_nxt = mb_x + 16'(MB_SIZE);
                end
            end else begin
                blk_nxt = blk + 4'd1;
            end
        end
        pos_nxt.row = mb_y_nxt + {12'd0, off_y};
        pos_nxt.col = mb_x_nxt + {12'd0, off_x};
        last_at_nxt = (blk_nxt == 4'd15) && (mb_x_nxt == MB_COL_LAST) && (mb_y_nxt == MB_ROW_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_x <= '0;
            mb_y <= '0;
            blk  <= '0;
        end else begin
            mb_x <= mb_x_nxt;
            mb_y <= mb_y_nxt;
            blk  <= blk_nxt;
        end
    end
`else
    localparam logic [15:0] COL_LAST = 16'(WIDTH - BLK_SIZE);
    localparam logic [15:0] ROW_LAST = 16'(LENGTH - BLK_SIZE);

    always_comb begin
        pos_nxt = pos;
        if (load || (xfer && last)) begin
            pos_nxt = '0;
        end else if (xfer) begin
            if (pos.col == COL_LAST) begin
                pos_nxt.col = '0;
                pos_nxt.row = pos.row + 16'(BLK_SIZE);
            end else begin
                pos_nxt.col = pos.col + 16'(BLK_SIZE);
            end
        end
        last_at_nxt = (pos_nxt.row == ROW_LAST) && (pos_nxt.col == COL_LAST);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos        <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            last       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pos        <= pos_nxt;
            valid      <= valid_nxt;
            busy       <= busy_nxt;
            last       <= last_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_intra_blk_scanner.sv
// Directed bench for intra_blk_scanner: a 32x16 instance for handshake/order cases
// and a 1280x720 instance for the full frame. Expectations follow INTRA_SCAN_MB_ORDER_EN.
module tb_intra_blk_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_full;
    logic        ready;
    logic        valid, last, busy, frame_done;
    logic [31:0] mbnumber;
    logic        valid_f, last_f, busy_f, done_f;
    logic [31:0] mb_f;

    int n_vec;
    int n_bad;

    logic [31:0] got_pos [0:63];
    logic        got_last [0:63];
    int          n_xfer, n_done, seq_err, stab_err, last_cnt, last_xfer_cyc, done_cyc;
    logic        first_valid;
    logic [31:0] first_pos;

    intra_blk_scanner #(.WIDTH(32), .LENGTH(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .valid      (valid),
        .mbnumber   (mbnumber),
        .last       (last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    intra_blk_scanner #(.WIDTH(1280), .LENGTH(720)) u_full (
        .clk        (clk),
        .reset      (reset),
        .start      (start_full),
        .ready      (ready),
        .valid      (valid_f),
        .mbnumber   (mb_f),
        .last       (last_f),
        .busy       (busy_f),
        .frame_done (done_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position of the idx-th block (0-based) of a frame w pixels wide.
    function automatic logic [31:0] exp_pos(input int idx, input int w);
        int x, y;
`ifdef INTRA_SCAN_MB_ORDER_EN
        int mbr, mb, b;
        mbr = w / 16;
        mb  = idx / 16;
        b   = idx % 16;
        x   = (mb % mbr) * 16 + ((b >> 2) & 1) * 8 + (b & 1) * 4;
        y   = (mb / mbr) * 16 + ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
`else
        int bpr;
        bpr = w / 4;
        x   = (idx % bpr) * 4;
        y   = (idx / bpr) * 4;
`endif
        return {y[15:0], x[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the small instance; returns at the negedge where frame_done is seen.
    task automatic run_small(input bit rnd, input bit do_start, input bit poke);
        logic [31:0] hold;
        logic        hold_last;
        bit          holding;
        n_xfer = 0; n_done = 0; seq_err = 0; stab_err = 0; last_cnt = 0;
        last_xfer_cyc = -1; done_cyc = -1; first_valid = 1'b0; first_pos = '1;
        holding = 1'b0; hold = '0; hold_last = 1'b0;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (cyc == 3 || cyc == 20);
            @(negedge clk);
            if (cyc == 0) begin
                first_valid = valid;
                first_pos   = mbnumber;
            end
            if (holding && (!valid || mbnumber !== hold || last !== hold_last)) stab_err++;
            holding = 1'b0;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (valid && ready) begin
                if (n_xfer < 64) begin
                    got_pos[n_xfer]  = mbnumber;
                    got_last[n_xfer] = last;
                end
                if (mbnumber !== exp_pos(n_xfer, 32)) seq_err++;
                if (last) last_cnt++;
                n_xfer++;
                last_xfer_cyc = cyc;
            end else if (valid) begin
                holding   = 1'b1;
                hold      = mbnumber;
                hold_last = last;
            end
            if (frame_done) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt, guard, fn, ferr, frow;
        logic        dseen, fdone, flast;
        logic [31:0] fpos;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; start = 1'b0; start_full = 1'b0; ready = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mbnumber", mbnumber, 32'd0);
        chk("rst_last", {31'd0, last}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Streaming frame with ready held high
        run_small(1'b0, 1'b1, 1'b0);
        chk("t1_first_valid", {31'd0, first_valid}, 32'd1);
        chk("t1_first_pos", first_pos, 32'd0);
        chk("t1_xfers", n_xfer, 32'd32);
        chk("t1_seq_err", seq_err, 32'd0);
        chk("t1_done_count", n_done, 32'd1);
        chk("t1_done_timing", done_cyc, last_xfer_cyc + 1);
        chk("t1_last_count", last_cnt, 32'd1);
        chk("t1_last_on_32", {31'd0, got_last[31]}, 32'd1);
`ifdef INTRA_SCAN_MB_ORDER_EN
        chk("t1_xfer2", got_pos[1], {16'd0, 16'd4});
        chk("t1_xfer3", got_pos[2], {16'd4, 16'd0});
        chk("t1_xfer5", got_pos[4], {16'd0, 16'd8});
        chk("t1_xfer17", got_pos[16], {16'd0, 16'd16});
`else
        chk("t1_xfer2", got_pos[1], {16'd0, 16'd4});
        chk("t1_xfer9", got_pos[8], {16'd4, 16'd0});
`endif
        chk("t1_xfer32", got_pos[31], {16'd12, 16'd28});

        // Back to IDLE after edge M+1; start at edge M+2 launches a new frame
        @(posedge clk); #1;
        chk("t1_post_done", {31'd0, frame_done}, 32'd0);
        chk("t1_post_valid", {31'd0, valid}, 32'd0);
        chk("t1_post_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_small(1'b0, 1'b0, 1'b0);
        chk("t2_first_valid", {31'd0, first_valid}, 32'd1);
        chk("t2_first_pos", first_pos, 32'd0);
        chk("t2_xfers", n_xfer, 32'd32);
        chk("t2_done_count", n_done, 32'd1);

        // start pulses during RUN are ignored
        @(posedge clk); #1;
        run_small(1'b0, 1'b1, 1'b1);
        chk("t3_xfers", n_xfer, 32'd32);
        chk("t3_seq_err", seq_err, 32'd0);
        chk("t3_done_count", n_done, 32'd1);

        // Pseudo-random back-pressure
        @(posedge clk); #1;
        run_small(1'b1, 1'b1, 1'b0);
        chk("t4_xfers", n_xfer, 32'd32);
        chk("t4_seq_err", seq_err, 32'd0);
        chk("t4_stable_err", stab_err, 32'd0);
        chk("t4_done_count", n_done, 32'd1);
        chk("t4_done_timing", done_cyc, last_xfer_cyc + 1);
        chk("t4_last_on_32", {31'd0, got_last[31]}, 32'd1);

        // Asynchronous reset after the 10th transfer
        @(posedge clk); #1;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        guard = 0;
        while (cnt < 10 && guard < 100) begin
            @(negedge clk);
            if (valid && ready) cnt++;
            guard++;
        end
        @(posedge clk); #1;
        chk("t5_pos_before_rst", mbnumber, exp_pos(10, 32));
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_mbnumber", mbnumber, 32'd0);
        dseen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (frame_done) dseen = 1'b1;
        end
        chk("t5_no_frame_done", {31'd0, dseen}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        run_small(1'b0, 1'b1, 1'b0);
        chk("t5_restart_pos", first_pos, 32'd0);
        chk("t5_restart_xfers", n_xfer, 32'd32);

        // Full 1280x720 frame
        @(posedge clk); #1;
        ready = 1'b1;
        start_full = 1'b1;
        @(posedge clk); #1;
        start_full = 1'b0;
        fn = 0; ferr = 0; frow = 0; fdone = 1'b0; flast = 1'b0; fpos = '0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            if (valid_f && ready) begin
                if (mb_f !== exp_pos(fn, 1280)) ferr++;
                if (mb_f[31:16] >= 16'd720) frow++;
                fpos  = mb_f;
                flast = last_f;
                fn++;
            end
            if (done_f) begin
                fdone = 1'b1;
                break;
            end
        end
        chk("full_done", {31'd0, fdone}, 32'd1);
        chk("full_xfers", fn, 32'd57600);
        chk("full_seq_err", ferr, 32'd0);
        chk("full_row_oob", frow, 32'd0);
        chk("full_final_pos", fpos, {16'd716, 16'd1276});
        chk("full_final_last", {31'd0, flast}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
